// File: rtl/stereolbm_axis_cambm_hls_deadlock_report_ctrl.sv
// stereolbm_axis_cambm_hls_deadlock_report_ctrl: debounces unit deadlock flags, walks the token from one origin and latches a sticky report
module stereolbm_axis_cambm_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID_W    = 2,
  parameter int DEBOUNCE     = 8,
  parameter int WALK_TIMEOUT = 1024
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [PROC_NUM-1:0]  proc_dl_detect_vec_i,
  input  logic [PROC_NUM-1:0]  proc_token_vec_i,
  input  logic                 report_clear_i,
  output logic                 dl_detect_in_o,
  output logic [PROC_NUM-1:0]  origin_vec_o,
  output logic                 token_clear_o,
  output logic                 deadlock_found_o,
  output logic [PROC_ID_W-1:0] deadlock_origin_id_o,
  output logic [PROC_NUM-1:0]  deadlock_member_vec_o,
  output logic                 walk_abort_o
);
  typedef enum logic [2:0] {IDLE, DEB, ORIGIN, WALK, REPORT} state_t;
  localparam logic [PROC_NUM-1:0] ONE = PROC_NUM'(1);
  state_t state_q, state_d;
  logic [PROC_ID_W-1:0] cand, cand_q, cand_d, id_d;
  logic [7:0] deb_q, deb_d;
  logic [15:0] walk_q, walk_d;
  logic [PROC_NUM-1:0] member_q, member_d, mem_rep_d, origin_d;
  logic ret, tmo, clr, dl_d, tc_d, found_d, abort_d;
  always_comb begin
    cand = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (proc_dl_detect_vec_i[i]) cand = PROC_ID_W'(i);
  end
  // the token must have left the origin for at least one cycle before it can count as returned
  assign ret = state_q == WALK && proc_token_vec_i[cand_q] && proc_dl_detect_vec_i[cand_q] && walk_q != '0;
  assign tmo = walk_q >= 16'(WALK_TIMEOUT - 2);
  assign clr = state_q == REPORT && report_clear_i;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q               <= IDLE;
      cand_q                <= '0;
      deb_q                 <= '0;
      walk_q                <= '0;
      member_q              <= '0;
      dl_detect_in_o        <= 1'b0;
      origin_vec_o          <= '0;
      token_clear_o         <= 1'b0;
      deadlock_found_o      <= 1'b0;
      deadlock_origin_id_o  <= '0;
      deadlock_member_vec_o <= '0;
      walk_abort_o          <= 1'b0;
    end else begin
      state_q               <= state_d;
      cand_q                <= cand_d;
      deb_q                 <= deb_d;
      walk_q                <= walk_d;
      member_q              <= member_d;
      dl_detect_in_o        <= dl_d;
      origin_vec_o          <= origin_d;
      token_clear_o         <= tc_d;
      deadlock_found_o      <= found_d;
      deadlock_origin_id_o  <= id_d;
      deadlock_member_vec_o <= mem_rep_d;
      walk_abort_o          <= abort_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    deb_d    = deb_q;
    walk_d   = walk_q;
    member_d = member_q;
    case (state_q)
      IDLE: if (|proc_dl_detect_vec_i) begin
        cand_d  = cand;
        deb_d   = 8'd1;
        state_d = 8'd1 >= 8'(DEBOUNCE) ? ORIGIN : DEB;
      end
      DEB: if (!proc_dl_detect_vec_i[cand_q]) begin
        deb_d   = '0;
        state_d = IDLE;
      end else begin
        deb_d   = deb_q + {7'd0, deb_q != 8'hFF};
        state_d = deb_d >= 8'(DEBOUNCE) ? ORIGIN : DEB;
      end
      ORIGIN: begin
        member_d = ONE << cand_q;
        walk_d   = '0;
        state_d  = WALK;
      end
      WALK: begin
        member_d = member_q | proc_token_vec_i;
        walk_d   = walk_q + {15'd0, walk_q != 16'hFFFF};
        state_d  = ret ? REPORT : tmo ? IDLE : WALK;
      end
      REPORT: state_d = report_clear_i ? IDLE : REPORT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dl_d      = state_d inside {ORIGIN, WALK, REPORT};
    origin_d  = state_d == ORIGIN ? ONE << cand_d : '0;
    tc_d      = ret;
    abort_d   = state_q == WALK && !ret && tmo;
    found_d   = state_d == REPORT;
    id_d      = ret ? cand_q : clr ? '0 : deadlock_origin_id_o;
    mem_rep_d = ret ? member_q | proc_token_vec_i : clr ? '0 : deadlock_member_vec_o;
  end
endmodule

// File: doc/stereolbm_axis_cambm_hls_deadlock_report_ctrl.md
Name: stereolbm_axis_cambm_hls_deadlock_report_ctrl

Overview:
Central controller downstream of the per-process deadlock detect units. Collects each unit's deadlock flag, filters transient flags, and picks a single origin process. It then drives the global detect/origin/token_clear signals back into the units and tracks the token walk around the dependency cycle. It latches a sticky report (origin ID plus the set of cycle members) for the debug/status interface.

Parameters:
PROC_NUM, 4, number of dataflow processes (detect units); range 2..32
PROC_ID_W, 2, width of process index; must equal clog2(PROC_NUM), minimum 1
DEBOUNCE, 8, consecutive cycles a flag must persist before it is accepted; range 1..255
WALK_TIMEOUT, 1024, maximum cycles allowed for the token walk; range 2..65535

Ports:
clock  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
proc_dl_detect_vec  in  PROC_NUM  dl_detect_out from each detect unit, bit i = process i
proc_token_vec  in  PROC_NUM  bit i = OR of token_in_vec at detect unit i
report_clear  in  1  single-cycle pulse; releases the sticky report
dl_detect_in  out  1  broadcast to all units; high from ORIGIN until return to IDLE
origin_vec  out  PROC_NUM  one-hot origin pulse to the selected unit
token_clear  out  1  broadcast single-cycle pulse when the token returns to the origin
deadlock_found  out  1  sticky, high in REPORT
deadlock_origin_id  out  PROC_ID_W  index of the origin process, valid while deadlock_found
deadlock_member_vec  out  PROC_NUM  processes the token visited, origin included
walk_abort  out  1  single-cycle pulse on walk timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, latched ID and member vector 0.
- All outputs are registered.
- cand = lowest set index of proc_dl_detect_vec (fixed priority, index 0 highest). any = |proc_dl_detect_vec.
- States: IDLE, DEBOUNCE, ORIGIN, WALK, REPORT.
- IDLE:
  - If any: latch cand into cand_reg, set deb_cnt=1, go to DEBOUNCE.
  - If DEBOUNCE==1: go directly to ORIGIN.
- DEBOUNCE:
  - If proc_dl_detect_vec[cand_reg]==0: go to IDLE and clear deb_cnt.
  - Else deb_cnt++. When deb_cnt reaches DEBOUNCE, go to ORIGIN.
  - A change in the lowest index does not restart the count; only bit cand_reg is tracked.
- ORIGIN (exactly 1 cycle):
  - Assert origin_vec = 1<<cand_reg and dl_detect_in=1.
  - Load member_vec = 1<<cand_reg and walk_cnt=0, then go to WALK.
- WALK:
  - dl_detect_in=1; each cycle member_vec |= proc_token_vec; walk_cnt++.
  - Token return: proc_token_vec[cand_reg]==1 && proc_dl_detect_vec[cand_reg]==1.
    - On the first cycle where this holds (and walk_cnt>=1), token_clear=1 for that cycle.
    - Then latch deadlock_origin_id=cand_reg and deadlock_member_vec=member_vec|proc_token_vec, and go to REPORT.
  - If walk_cnt reaches WALK_TIMEOUT-1 without return: walk_abort=1 for one cycle, dl_detect_in drops, go to IDLE. Latched report is left unchanged.
  - Return and timeout in the same cycle: return wins.
- REPORT:
  - deadlock_found=1, dl_detect_in=1; ID and member vector held.
  - Ignore all detect and token inputs.
  - report_clear: next cycle deadlock_found=0, dl_detect_in=0, member vector and ID cleared, go to IDLE.
- report_clear outside REPORT is ignored.
- Counters saturate and never wrap. deb_cnt is 8-bit. walk_cnt is 16-bit.
- Reset asserted mid-walk or mid-report forces the reset values immediately (asynchronous).

Test Plan:
- Idle: PROC_NUM=4, DEBOUNCE=8, proc_dl_detect_vec=0 for 100 cycles -> all outputs 0, FSM remains IDLE.
- Glitch: proc_dl_detect_vec=4'b0100 for 5 cycles then 0 -> no origin_vec pulse, return to IDLE, dl_detect_in stays 0.
- Normal: bits 1 and 2 held high for 8 cycles -> origin_vec=4'b0010 for one cycle, dl_detect_in rises. Token then shows 4'b0100, then 4'b1000, then 4'b0010 with bit 1 detect high -> token_clear 1 cycle, deadlock_found=1, id=1, member_vec=4'b1110.
- Timeout: WALK_TIMEOUT=16, token never returns -> walk_abort pulses exactly 16 cycles after ORIGIN, dl_detect_in=0, deadlock_found stays 0.
- Clear and re-arm: in REPORT, pulse report_clear -> deadlock_found=0 and member_vec=0 the next cycle. With bit 3 held high, a new detection restarts and yields id=3.
- Async reset mid-WALK: assert reset between clock edges -> all outputs 0 immediately, before the next edge; normal operation after release.
